// File: rtl/can_level_frame_rx_if.sv
// Bit-stage strobe/bit pair plus the received-frame result bundle of can_level_frame_rx.
interface can_level_frame_rx_if;
  logic        req;
  logic        rbit;
  logic        tbit;
  logic        rx_valid;
  logic        rx_ide;
  logic        rx_rtr;
  logic [28:0] rx_id;
  logic [3:0]  rx_len;
  logic [63:0] rx_data;
  logic        rx_err;
  logic [1:0]  rx_err_code;

  modport master (
    output req, rbit,
    input  tbit, rx_valid, rx_ide, rx_rtr, rx_id, rx_len, rx_data, rx_err, rx_err_code
  );

  modport slave (
    input  req, rbit,
    output tbit, rx_valid, rx_ide, rx_rtr, rx_id, rx_len, rx_data, rx_err, rx_err_code
  );
endinterface

// File: rtl/can_level_frame_rx.sv
// CAN frame receiver: SOF detect, de-stuffing, field parse, CRC-15 check, ACK-slot drive.
// Advances only on req strobes; accepted frames and errors appear as one-cycle pulses after the deciding req.
module can_level_frame_rx #(
  parameter logic [28:0] LOCAL_ID      = 29'h0,
  parameter logic [28:0] LOCAL_ID_MASK = 29'h0
) (
  input logic                 rstn,
  input logic                 clk,
  can_level_frame_rx_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_ID_A, S_SRR_RTR, S_IDE, S_ID_B, S_RTR_B, S_R1, S_R0,
    S_DLC, S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_WAIT_IDLE
  } state_e;

  localparam logic [14:0] CRC_POLY  = 15'h4599;
  localparam logic [1:0]  ERR_STUFF = 2'd1;
  localparam logic [1:0]  ERR_FORM  = 2'd2;
  localparam logic [1:0]  ERR_CRC   = 2'd3;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [2:0]  run_q, run_d;
  logic [14:0] crc_q, crc_d;
  logic [13:0] crc_rx_q, crc_rx_d;
  logic        crc_ok_q, crc_ok_d;
  logic [2:0]  rec_q, rec_d;
  logic [28:0] id_q, id_d;
  logic        ide_q, ide_d;
  logic        rtr_q, rtr_d;
  logic [2:0]  dlc_q, dlc_d;
  logic [3:0]  len_q, len_d;
  logic [63:0] data_q, data_d;
  logic        tbit_q, tbit_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_ide_q, rx_ide_d;
  logic        rx_rtr_q, rx_rtr_d;
  logic [28:0] rx_id_q, rx_id_d;
  logic [3:0]  rx_len_q, rx_len_d;
  logic [63:0] rx_data_q, rx_data_d;
  logic        rx_err_q, rx_err_d;
  logic [1:0]  rx_err_code_q, rx_err_code_d;

  logic        b;
  logic        in_stuff_zone;
  logic        in_crc_zone;
  logic        stuff_bit;
  logic [14:0] crc_next;
  logic [3:0]  dlc_full;
  logic        id_match;
  logic        err;
  logic [1:0]  err_code;

  assign b             = bus.rbit;
  assign in_stuff_zone = state_q inside {S_ID_A, S_SRR_RTR, S_IDE, S_ID_B, S_RTR_B,
                                         S_R1, S_R0, S_DLC, S_DATA, S_CRC};
  assign in_crc_zone   = in_stuff_zone && (state_q != S_CRC);
  // A stuff bit owed after the last CRC bit is consumed while sitting in CRC_DEL.
  assign stuff_bit     = (run_q == 3'd5) && (in_stuff_zone || state_q == S_CRC_DEL);
  assign crc_next      = {crc_q[13:0], 1'b0} ^ ((b ^ crc_q[14]) ? CRC_POLY : 15'h0);
  assign dlc_full      = {dlc_q, b};
  assign id_match      = ((id_q ^ LOCAL_ID) & LOCAL_ID_MASK) == 29'h0;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    run_d         = run_q;
    crc_d         = crc_q;
    crc_rx_d      = crc_rx_q;
    crc_ok_d      = crc_ok_q;
    rec_d         = rec_q;
    id_d          = id_q;
    ide_d         = ide_q;
    rtr_d         = rtr_q;
    dlc_d         = dlc_q;
    len_d         = len_q;
    data_d        = data_q;
    tbit_d        = tbit_q;
    rx_valid_d    = 1'b0;
    rx_ide_d      = rx_ide_q;
    rx_rtr_d      = rx_rtr_q;
    rx_id_d       = rx_id_q;
    rx_len_d      = rx_len_q;
    rx_data_d     = rx_data_q;
    rx_err_d      = 1'b0;
    rx_err_code_d = rx_err_code_q;
    err           = 1'b0;
    err_code      = 2'd0;

    if (bus.req) begin
      if (stuff_bit) begin
        if (b == last_q) begin
          err      = 1'b1;
          err_code = ERR_STUFF;
        end else begin
          last_d = b;
          run_d  = 3'd1;
        end
      end else begin
        if (in_stuff_zone) begin
          run_d  = (b == last_q) ? run_q + 3'd1 : 3'd1;
          last_d = b;
        end
        if (in_crc_zone) crc_d = crc_next;

        case (state_q)
          S_IDLE: begin
            if (!b) begin
              state_d = S_ID_A;
              cnt_d   = 7'd0;
              crc_d   = 15'h0;
              last_d  = 1'b0;
              run_d   = 3'd1;
              id_d    = 29'h0;
              ide_d   = 1'b0;
              rtr_d   = 1'b0;
              dlc_d   = 3'd0;
              len_d   = 4'd0;
              data_d  = 64'h0;
            end
          end
          S_ID_A: begin
            id_d = {id_q[27:0], b};
            if (cnt_q == 7'd10) begin
              state_d = S_SRR_RTR;
              cnt_d   = 7'd0;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          S_SRR_RTR: begin
            rtr_d   = b;
            state_d = S_IDE;
          end
          S_IDE: begin
            ide_d   = b;
            cnt_d   = 7'd0;
            state_d = b ? S_ID_B : S_R0;
          end
          S_ID_B: begin
            id_d = {id_q[27:0], b};
            if (cnt_q == 7'd17) state_d = S_RTR_B;
            else                cnt_d   = cnt_q + 7'd1;
          end
          S_RTR_B: begin
            rtr_d   = b;
            state_d = S_R1;
          end
          S_R1: state_d = S_R0;
          S_R0: begin
            state_d = S_DLC;
            cnt_d   = 7'd0;
          end
          S_DLC: begin
            dlc_d = dlc_full[2:0];
            if (cnt_q == 7'd3) begin
              cnt_d = 7'd0;
              if (rtr_q)                len_d = 4'd0;
              else if (dlc_full > 4'd8) len_d = 4'd8;
              else                      len_d = dlc_full;
              state_d = (rtr_q || dlc_full == 4'd0) ? S_CRC : S_DATA;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          S_DATA: begin
            // Bytes arrive MSB first; byte n lands in data[8n+7:8n].
            data_d[{cnt_q[5:3], ~cnt_q[2:0]}] = b;
            if (cnt_q == {len_q, 3'b000} - 7'd1) begin
              state_d = S_CRC;
              cnt_d   = 7'd0;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          S_CRC: begin
            crc_rx_d = {crc_rx_q[12:0], b};
            if (cnt_q == 7'd14) begin
              state_d  = S_CRC_DEL;
              crc_ok_d = ({crc_rx_q, b} == crc_q);
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          S_CRC_DEL: begin
            if (!crc_ok_q) begin
              err      = 1'b1;
              err_code = ERR_CRC;
            end else if (!b) begin
              err      = 1'b1;
              err_code = ERR_FORM;
            end else begin
              tbit_d  = 1'b0;
              state_d = S_ACK;
            end
          end
          S_ACK: begin
            tbit_d  = 1'b1;
            state_d = S_ACK_DEL;
          end
          S_ACK_DEL: begin
            if (!b) begin
              err      = 1'b1;
              err_code = ERR_FORM;
            end else begin
              state_d = S_EOF;
              cnt_d   = 7'd0;
            end
          end
          S_EOF: begin
            if (!b) begin
              err      = 1'b1;
              err_code = ERR_FORM;
            end else if (cnt_q == 7'd6) begin
              state_d = S_IDLE;
              if (crc_ok_q && id_match) begin
                rx_valid_d = 1'b1;
                rx_ide_d   = ide_q;
                rx_rtr_d   = rtr_q;
                rx_id_d    = id_q;
                rx_len_d   = len_q;
                rx_data_d  = data_q;
              end
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          S_WAIT_IDLE: begin
            if (!b) begin
              rec_d = 3'd0;
            end else if (rec_q == 3'd6) begin
              rec_d   = 3'd0;
              state_d = S_IDLE;
            end else begin
              rec_d = rec_q + 3'd1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end

      if (err) begin
        state_d       = S_WAIT_IDLE;
        rec_d         = 3'd0;
        tbit_d        = 1'b1;
        rx_err_d      = 1'b1;
        rx_err_code_d = err_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cnt_q         <= 7'd0;
      last_q        <= 1'b0;
      run_q         <= 3'd0;
      crc_q         <= 15'h0;
      crc_rx_q      <= 14'h0;
      crc_ok_q      <= 1'b0;
      rec_q         <= 3'd0;
      id_q          <= 29'h0;
      ide_q         <= 1'b0;
      rtr_q         <= 1'b0;
      dlc_q         <= 3'd0;
      len_q         <= 4'd0;
      data_q        <= 64'h0;
      tbit_q        <= 1'b1;
      rx_valid_q    <= 1'b0;
      rx_ide_q      <= 1'b0;
      rx_rtr_q      <= 1'b0;
      rx_id_q       <= 29'h0;
      rx_len_q      <= 4'd0;
      rx_data_q     <= 64'h0;
      rx_err_q      <= 1'b0;
      rx_err_code_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      run_q         <= run_d;
      crc_q         <= crc_d;
      crc_rx_q      <= crc_rx_d;
      crc_ok_q      <= crc_ok_d;
      rec_q         <= rec_d;
      id_q          <= id_d;
      ide_q         <= ide_d;
      rtr_q         <= rtr_d;
      dlc_q         <= dlc_d;
      len_q         <= len_d;
      data_q        <= data_d;
      tbit_q        <= tbit_d;
      rx_valid_q    <= rx_valid_d;
      rx_ide_q      <= rx_ide_d;
      rx_rtr_q      <= rx_rtr_d;
      rx_id_q       <= rx_id_d;
      rx_len_q      <= rx_len_d;
      rx_data_q     <= rx_data_d;
      rx_err_q      <= rx_err_d;
      rx_err_code_q <= rx_err_code_d;
    end
  end

  assign bus.tbit        = tbit_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_ide      = rx_ide_q;
  assign bus.rx_rtr      = rx_rtr_q;
  assign bus.rx_id       = rx_id_q;
  assign bus.rx_len      = rx_len_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_err      = rx_err_q;
  assign bus.rx_err_code = rx_err_code_q;

endmodule

// File: doc/can_level_frame_rx.md
Name: can_level_frame_rx

Overview:
- Frame-level receiver that sits directly downstream of the CAN bit-timing stage.
- Consumes the per-bit strobe `req` and sampled bit `rbit`, and drives `tbit` back to the bit stage.
- Performs SOF detection, bit de-stuffing, field parsing (standard and extended), CRC-15 check and ACK-slot generation.
- Delivers accepted frames to user logic with a one-cycle valid pulse and reports errors with a one-cycle error pulse.

Parameters:
LOCAL_ID, 29'h0, acceptance ID; a standard ID is compared zero-extended as id[10:0].
LOCAL_ID_MASK, 29'h0, acceptance mask; 1 = bit must match, all-zero accepts everything.

Ports:
rstn  input  1  asynchronous active-low reset.
clk  input  1  system clock.
req  input  1  bit strobe from the bit-timing stage, one cycle wide.
rbit  input  1  sampled bus bit, valid when req=1.
tbit  output  1  next bit to transmit, registered, updated only in the cycle req=1.
rx_valid  output  1  one-cycle pulse, frame accepted.
rx_ide  output  1  1 = extended frame.
rx_rtr  output  1  remote frame.
rx_id  output  29  received ID, standard frames zero-extended.
rx_len  output  4  data length 0..8.
rx_data  output  64  byte 0 in [7:0], unused bytes 0.
rx_err  output  1  one-cycle error pulse.
rx_err_code  output  2  1 = stuff, 2 = form, 3 = CRC; valid with rx_err.

Behaviour:
- Reset values:
  - tbit=1, rx_valid=0, rx_err=0, rx_err_code=0, rx_ide=0, rx_rtr=0, rx_id=0, rx_len=0, rx_data=0.
  - State IDLE, recessive counter 0.
- All processing advances only on cycles with req=1. rx_valid and rx_err deassert on every other cycle.
- States: IDLE, ID_A (11), SRR_RTR, IDE, ID_B (18), RTR_B, R1, R0, DLC (4), DATA (8*len), CRC (15), CRC_DEL, ACK, ACK_DEL, EOF (7), WAIT_IDLE.
- IDLE:
  - rbit=0 starts a frame (SOF).
  - Clear the CRC register, set last-bit to 0 and run-length to 1.
- De-stuffing, active from SOF through the last CRC bit:
  - After 5 consecutive equal bits, the next bit is a stuff bit. It is discarded, excluded from CRC, and run-length resets to 1.
  - If the stuff bit equals the previous bit: stuff error.
- CRC:
  - CRC-15, polynomial 0x4599, initial value 0.
  - Covers de-stuffed bits from SOF through the last data bit.
  - The received 15 CRC bits are compared against the register.
- Field parsing:
  - ID_A bits are shifted MSB first.
  - IDE=0: the bit after ID_A is RTR, followed by r0, then DLC.
  - IDE=1: SRR, IDE, ID_B, RTR, r1, r0, DLC; rx_id = {ID_A, ID_B}.
  - len = min(DLC, 8), and 0 if RTR=1.
  - DATA is skipped when len=0.
- Form check: CRC_DEL, ACK_DEL and every EOF bit must be 1, otherwise form error.
- ACK timing:
  - On the req that samples CRC_DEL: tbit <= 0 if CRC matched and CRC_DEL=1, else tbit <= 1.
  - On the req that samples ACK: tbit <= 1.
  - tbit is therefore dominant for exactly the ACK slot.
  - The ACK-slot value is ignored by the receiver.
- Acceptance: match = ((rx_id ^ LOCAL_ID) & LOCAL_ID_MASK) == 0.
- Completion:
  - On the 7th EOF bit req, if CRC is ok and match=1: one cycle later assert rx_valid with all rx_* fields stable.
  - Fields hold until the next accepted frame.
  - Non-matching frames are still ACKed but produce no rx_valid.
- Errors:
  - On error, pulse rx_err with its code on the cycle after the offending req, force tbit=1, and enter WAIT_IDLE.
  - A CRC mismatch is reported at CRC_DEL.
  - WAIT_IDLE returns to IDLE after 7 consecutive recessive samples; a dominant sample restarts the count.
- Boundary cases:
  - A dominant bit in any EOF position is a form error; no rx_valid is issued.
  - A stuff bit falling immediately after the last CRC bit is still checked.
  - DLC of 9..15 gives len=8.
  - Reset mid-frame returns to IDLE with tbit=1 at once, with no pulses.

Test Plan:
- Standard data frame, ID 0x123, DLC 2, data AB CD, correct CRC from the bench model, masks 0:
  - tbit=0 only during the ACK slot.
  - rx_valid pulse with rx_id=0x123, rx_ide=0, rx_len=2, rx_data=0xCDAB.
- Extended remote frame, ID 0x1ABCDE12, DLC 4:
  - rx_valid with rx_ide=1, rx_rtr=1, rx_len=0, rx_id=0x1ABCDE12.
- ID 0x7FF with long identical runs that force stuffing, plus one injected bad stuff bit:
  - rx_err with code 1.
  - No ACK.
  - Returns to IDLE after 7 recessive bits.
- Frame with one CRC bit flipped:
  - tbit stays 1 through ACK.
  - rx_err with code 3.
  - No rx_valid.
- Filter LOCAL_ID=0x100, mask 0x7F0, frame ID 0x123:
  - ACK is driven.
  - No rx_valid.
- DLC=12 with 8 data bytes, then a dominant 3rd EOF bit:
  - rx_err with code 2.
  - No rx_valid.
- Reset asserted mid-DATA:
  - All outputs return to reset values.
  - The next frame is received correctly.
